// File: rtl/alu_div_seq.sv
// alu_div_seq: sequences a shared combinational ALU as a 4-bit unsigned restoring divider,
// producing one quotient bit per clock behind a start/busy/done handshake.
module alu_div_seq #(
    parameter int         W      = 4,
    parameter logic [4:0] F_SUB  = 5'b00011,
    parameter logic [4:0] F_IDLE = 5'b00000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [4:0]   alu_f,
    input  logic [W-1:0] alu_y
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                 state;
    logic [W-1:0]           r, q, d;
    logic [$clog2(W)-1:0]   cnt;
    logic [W:0]             s;
    logic                   ge;
    logic [W-1:0]           r_nx, q_nx;
    // Partial remainder shifted left with the next dividend bit; a set S[W] always means S >= D.
    always_comb begin
        s       = {r, q[cnt]};
        ge      = s >= {1'b0, d};
        r_nx    = ge ? alu_y : s[W-1:0];
        q_nx    = q;
        q_nx[cnt] = ge;
    end
    assign busy  = state == RUN;
    assign done  = state == DONE;
    assign alu_f = busy ? F_SUB : F_IDLE;
    assign alu_a = busy ? s[W-1:0] : '0;
    assign alu_b = busy ? d : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    d   <= divisor;
                    q   <= dividend;
                    r   <= '0;
                    cnt <= '1;
                    if (divisor == '0) begin
                        state       <= DONE;
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end else begin
                        state       <= RUN;
                        div_by_zero <= 1'b0;
                    end
                end
                RUN: begin
                    r <= r_nx;
                    q <= q_nx;
                    if (cnt == '0) begin
                        state     <= DONE;
                        quotient  <= q_nx;
                        remainder <= r_nx;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_div_seq.sv
// tb_alu_div_seq: directed and exhaustive checks of alu_div_seq with a queue-based scoreboard
// and a behavioural model of the shared ALU.
module tb_alu_div_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] dividend = '0, divisor = '0;
    logic       busy, done, div_by_zero;
    logic [3:0] quotient, remainder, alu_a, alu_b, alu_y;
    logic [4:0] alu_f;
    logic [3:0] cur_d = '0;
    logic [8:0] sb[$];
    logic [8:0] e;
    int checks = 0, errors = 0;

    alu_div_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .quotient(quotient),
        .remainder(remainder), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y)
    );

    assign alu_y = (alu_f == 5'b00011) ? 4'(alu_a - alu_b) : 4'h0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (busy) begin
            chk("alu_f_run", alu_f, 5'b00011);
            chk("alu_b_run", alu_b, cur_d);
        end
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("quotient", quotient, e[8:5]);
                chk("remainder", remainder, e[4:1]);
                chk("div_by_zero", div_by_zero, e[0]);
                chk("alu_f_done", alu_f, 5'b00000);
                chk("busy_in_done", busy, 0);
            end
        end
    end

    task automatic wait_done(input int lat, input int bsy, input string nm);
        int n = 0, nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) nb++;
        end while (!done && n < 20);
        chk({nm, "_latency"}, n, lat);
        chk({nm, "_busy_cycles"}, nb, bsy);
    endtask

    task automatic do_div(input logic [3:0] a, input logic [3:0] b, input string nm);
        logic [3:0] eq, er;
        @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        eq = (b == 0) ? 4'hF : a / b;
        er = (b == 0) ? a : a % b;
        sb.push_back({eq, er, b == 0});
        @(posedge clk);
        cur_d = b;
        #1;
        start = 1'b0;
        dividend = 4'($urandom);
        divisor = 4'($urandom);
        wait_done(b == 0 ? 1 : 5, b == 0 ? 0 : 4, nm);
        @(posedge clk);
    endtask

    initial begin
        #1;
        chk("rst_outs", {busy, done, div_by_zero, quotient, remainder, alu_a, alu_b, alu_f}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // hand-computed directed vectors
        do_div(4'd13, 4'd4, "d13_4");
        do_div(4'd15, 4'd1, "d15_1");
        do_div(4'd15, 4'd15, "d15_15");
        do_div(4'd7, 4'd9, "d7_9");
        do_div(4'd14, 4'd13, "d14_13");
        do_div(4'd14, 4'd0, "d14_0");
        do_div(4'd10, 4'd3, "d10_3_clr_dbz");
        // start held high: 13/4 then 9/2 back-to-back, operands changed mid-run
        @(negedge clk);
        start = 1'b1;
        dividend = 4'd13;
        divisor = 4'd4;
        sb.push_back({4'd3, 4'd1, 1'b0});
        sb.push_back({4'd4, 4'd1, 1'b0});
        @(posedge clk);
        cur_d = 4'd4;
        #1;
        dividend = 4'd9;
        divisor = 4'd2;
        wait_done(5, 4, "b2b_first");
        @(posedge clk);
        @(posedge clk);
        cur_d = 4'd2;
        #1;
        start = 1'b0;
        wait_done(5, 4, "b2b_second");
        @(posedge clk);
        // asynchronous reset during the second RUN cycle
        @(negedge clk);
        start = 1'b1;
        dividend = 4'd13;
        divisor = 4'd4;
        @(posedge clk);
        cur_d = 4'd4;
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        chk("busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_outs", {busy, done, div_by_zero, quotient, remainder, alu_a, alu_b, alu_f}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_div(4'd10, 4'd3, "post_rst_10_3");
        // exhaustive operand sweep
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                do_div(4'(a), 4'(b), "sweep");
        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
